// File: rtl/lut_neuron_pkg.sv
// Shared types and helpers for the programmable truth-table neuron.
package lut_neuron_pkg;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_CFG   = 2'd3
    } state_e;

    function automatic int depth_of(input int in_bits);
        return 1 << in_bits;
    endfunction

endpackage

// File: rtl/lut_table_ram.sv
// Single-write, async-read distributed RAM holding one neuron's truth table.
module lut_table_ram #(
    parameter int AW    = 6,
    parameter int DW    = 1,
    parameter int DEPTH = 64
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    (* ram_style = "distributed", rom_style = "distributed" *)
    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/lut_neuron_prog.sv
// Runtime-programmable LUT neuron: clear-on-reset table, config port,
// and a valid/ready lookup stream with a registered result.
module lut_neuron_prog
    import lut_neuron_pkg::*;
#(
    parameter int IN_BITS  = 6,
    parameter int OUT_BITS = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [IN_BITS-1:0]  in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [OUT_BITS-1:0] out_data,
    input  logic                cfg_mode,
    input  logic                cfg_we,
    input  logic [IN_BITS-1:0]  cfg_addr,
    input  logic [OUT_BITS-1:0] cfg_wdata,
    output logic                cfg_active,
    output logic                cfg_ack,
    output logic                cfg_err
);

    localparam int DEPTH = depth_of(IN_BITS);
    localparam logic [IN_BITS:0] LAST = (IN_BITS+1)'(DEPTH - 1);

    state_e              state_q, state_d;
    logic [IN_BITS:0]    clear_cnt_q, clear_cnt_d;
    logic                out_valid_q, out_valid_d;
    logic [OUT_BITS-1:0] out_data_q, out_data_d;
    logic                cfg_ack_q, cfg_ack_d;
    logic                cfg_err_q, cfg_err_d;

    logic                wr_en;
    logic [IN_BITS-1:0]  wr_addr;
    logic [OUT_BITS-1:0] wr_data;
    logic [OUT_BITS-1:0] rd_data;
    logic                in_ready_c;
    logic                xfer;

    always_comb begin
        state_d     = state_q;
        clear_cnt_d = clear_cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        cfg_ack_d   = 1'b0;
        cfg_err_d   = cfg_err_q;
        wr_en       = 1'b0;
        wr_addr     = cfg_addr;
        wr_data     = cfg_wdata;

        in_ready_c = (state_q == ST_RUN) && (!out_valid_q || out_ready);
        xfer       = in_valid && in_ready_c;

        if (xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = rd_data;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            ST_CLEAR: begin
                wr_en       = 1'b1;
                wr_addr     = clear_cnt_q[IN_BITS-1:0];
                wr_data     = '0;
                clear_cnt_d = clear_cnt_q + 1'b1;
                if (clear_cnt_q == LAST) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (cfg_mode) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                // Move on as soon as the held result has been taken.
                if (!out_valid_d) state_d = ST_CFG;
            end
            ST_CFG: begin
                if (cfg_we) begin
                    wr_en     = 1'b1;
                    cfg_ack_d = 1'b1;
                end
                if (!cfg_mode) state_d = ST_RUN;
            end
            default: state_d = ST_CLEAR;
        endcase

        if (cfg_we && state_q != ST_CFG) cfg_err_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_CLEAR;
            clear_cnt_q <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            cfg_ack_q   <= 1'b0;
            cfg_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            clear_cnt_q <= clear_cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            cfg_ack_q   <= cfg_ack_d;
            cfg_err_q   <= cfg_err_d;
        end
    end

    lut_table_ram #(
        .AW    (IN_BITS),
        .DW    (OUT_BITS),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (wr_en && !rst),
        .waddr (wr_addr),
        .wdata (wr_data),
        .raddr (in_data),
        .rdata (rd_data)
    );

    assign in_ready   = in_ready_c;
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign cfg_active = (state_q == ST_CFG);
    assign cfg_ack    = cfg_ack_q;
    assign cfg_err    = cfg_err_q;

endmodule

// File: doc/lut_neuron_prog.md
Name: lut_neuron_prog

Overview:
- Parametrised, runtime-programmable truth-table neuron. Successor to the fixed, combinational per-neuron ROMs in the logicnets layers.
- Holds a 2^IN_BITS x OUT_BITS table that is cleared after reset and written through a config port.
- Serves lookups through a valid/ready stream with a registered output.
- Lets one netlist host any trained neuron without resynthesis; instantiated per neuron inside a layer wrapper.

Parameters:
- IN_BITS, 6, address width (fan-in bits); table depth = 2^IN_BITS.
- OUT_BITS, 1, output activation width.
- DEPTH, 2**IN_BITS, derived; must not be overridden.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  lookup request valid.
- in_ready  out  1  block accepts a lookup this cycle.
- in_data  in  IN_BITS  lookup address.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_data  out  OUT_BITS  table[in_data] of the accepted request.
- cfg_mode  in  1  level; high requests config mode.
- cfg_we  in  1  table write strobe.
- cfg_addr  in  IN_BITS  write address.
- cfg_wdata  in  OUT_BITS  write data.
- cfg_active  out  1  FSM is in CFG; writes are accepted.
- cfg_ack  out  1  one-cycle pulse the cycle after a committed write.
- cfg_err  out  1  sticky flag: write attempted outside CFG.

Behaviour:
- Reset values:
  - in_ready=0, out_valid=0, out_data=0.
  - cfg_active=0, cfg_ack=0, cfg_err=0.
  - FSM=CLEAR, clear counter=0.
- CLEAR state:
  - Writes 0 to table[clear_cnt] each cycle; clear_cnt increments.
  - Leaves to RUN the cycle after clear_cnt=DEPTH-1 is written, so CLEAR lasts exactly DEPTH cycles.
  - in_ready=0 throughout; cfg_mode is ignored.
- RUN state:
  - in_ready = !out_valid || out_ready.
  - A transfer is in_valid && in_ready. It loads out_data = table[in_data] and sets out_valid=1 on the next edge. Latency is 1 cycle.
  - out_valid clears on out_ready when there is no new transfer. out_data holds while out_valid && !out_ready.
  - Back-to-back transfers give full throughput at 1 per cycle.
- RUN -> DRAIN when cfg_mode=1, sampled at the edge.
  - In DRAIN, in_ready=0 and the pending result is held until out_ready.
  - DRAIN -> CFG on the first cycle with out_valid=0, which may be the entry cycle.
- CFG state:
  - cfg_active=1, in_ready=0.
  - cfg_we writes table[cfg_addr]=cfg_wdata at the edge; cfg_ack=1 on the following cycle.
  - CFG -> RUN when cfg_mode=0. A write presented in that same cycle is still committed and acked.
- Writes outside CFG (cfg_we=1 in CLEAR, RUN or DRAIN):
  - Not committed, no ack.
  - cfg_err set; it clears only on rst.
- A lookup issued in the first RUN cycle after CFG sees all committed writes (write-then-read coherence).
- rst asserted mid-CFG or mid-stream:
  - Aborts all activity and drops any in-flight result (out_valid=0 next cycle).
  - Restarts CLEAR; earlier table contents are discarded.
- Table storage:
  - Distributed RAM, asynchronous read, registered output.
  - One write port, shared by clear and cfg via a mux.
- Widths are exact; no arithmetic beyond the clear counter, which is IN_BITS+1 bits to detect wrap.

Decomposition:
- Package lut_neuron_pkg:
  - FSM state enum {CLEAR, RUN, DRAIN, CFG}.
  - Function depth_of(IN_BITS).
- Sub-module lut_table_ram: 1W/1R-async distributed RAM, DEPTH x OUT_BITS, rom_style/ram_style distributed.
- Top: FSM, clear counter, handshake, output register.

Test Plan:
1. rst 1 cycle, IN_BITS=6 -> in_ready=0 for exactly 64 cycles. Then in_ready=1; lookups of 0x00, 0x2A, 0x3F all return 0 with out_valid one cycle after acceptance.
2. cfg_mode=1, write table[a]=a[0]^a[5] for all 64 addresses, cfg_mode=0 -> 64 cfg_ack pulses, cfg_err=0. Streaming 0..63 back-to-back with out_ready=1 returns the expected pattern at 1 result/cycle (e.g. 0x01->1, 0x21->0).
3. out_ready=0 for 5 cycles with a result pending -> out_data stable, in_ready=0, no loss. Release gives one result; the next lookup is accepted the same cycle.
4. cfg_mode=1 while out_valid=1 and out_ready=0 -> stays in DRAIN (cfg_active=0). Write attempted now sets cfg_err=1 and the table is unchanged. CFG is entered the cycle after out_ready=1.
5. Write table[0x10]=1 in the same cycle cfg_mode falls -> ack pulses. Lookup of 0x10 on the first RUN cycle returns 1.
6. rst mid-CFG after 3 writes -> 64-cycle CLEAR repeats. Lookup of a previously written address returns 0; cfg_err=0.
